rot_addr_gen: RTL and testbench

- Rotate-core address sequencer directly downstream of the APB register interface.
- Consumes SRC/DST base, H, W, MODE, DIR, START, RESET and INTR_MASK from the register block. Returns NEW_H/NEW_W and the BEF/AFT status flags to it.
- Emits one source-read/destination-write address pair per pixel to the DMA engine over a valid/ready handshake. Raises an interrupt on job accept and on job completion.

---
 rtl/rot_addr_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_rot_addr_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rot_addr_gen.sv
// Rotate-core address sequencer: walks the source image in raster order and emits src/dst address pairs.
// Optional busy-cycle counter is built when ROTAG_PERF_CNT_EN is defined.
module rot_addr_gen #(
    parameter int unsigned PIX_BYTES = 4,
    parameter int unsigned DIM_W     = 16
) (
    input  logic             I_ROTAG_CLK,
    input  logic             I_ROTAG_RESET,
    input  logic [31:0]      I_ROTAG_SRC_IMG,
    input  logic [31:0]      I_ROTAG_DST_IMG,
    input  logic [DIM_W-1:0] I_ROTAG_IMG_H,
    input  logic [DIM_W-1:0] I_ROTAG_IMG_W,
    input  logic [1:0]       I_ROTAG_MODE,
    input  logic             I_ROTAG_DIR,
    input  logic             I_ROTAG_START,
    input  logic             I_ROTAG_SOFT_RST,
    input  logic             I_ROTAG_INTR_MASK,
    input  logic             I_ROTAG_INTR_CLEAR,
    input  logic             I_ROTAG_ADDR_READY,
    output logic [31:0]      O_ROTAG_SRC_ADDR,
    output logic [31:0]      O_ROTAG_DST_ADDR,
    output logic             O_ROTAG_ADDR_VALID,
    output logic [DIM_W-1:0] O_ROTAG_NEW_H,
    output logic [DIM_W-1:0] O_ROTAG_NEW_W,
    output logic             O_ROTAG_BUSY,
    output logic             O_ROTAG_BEF_MASK,
    output logic             O_ROTAG_AFT_MASK,
    output logic             O_ROTAG_INTR,
    output logic [31:0]      O_ROTAG_PERF_CYC
);

    localparam logic [31:0] PIX = 32'(PIX_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic             start_prev_q;
    logic [DIM_W-1:0] h_q, h_d, w_q, w_d;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d, dst_row_q, dst_row_d;
    logic [31:0]      col_step_q, col_step_d, row_step_q, row_step_d;
    logic [DIM_W-1:0] new_h_q, new_h_d, new_w_q, new_w_d;
    logic             valid_q, valid_d, busy_q, busy_d;
    logic             bef_q, bef_d, aft_q, aft_d;

    logic             start_edge_c, accept_c, last_c, row_end_c, bef_set_c, aft_set_c;
    logic [1:0]       rot_c;
    logic [31:0]      h32_c, w32_c, dst_start_c, col_step_c, row_step_c;

    // Effective rotation and the first-pair / stepping values derived from the live config
    always_comb begin
        rot_c       = I_ROTAG_DIR ? 2'(2'd0 - I_ROTAG_MODE) : I_ROTAG_MODE;
        h32_c       = 32'(I_ROTAG_IMG_H);
        w32_c       = 32'(I_ROTAG_IMG_W);
        dst_start_c = I_ROTAG_DST_IMG;
        col_step_c  = PIX;
        row_step_c  = w32_c * PIX;
        case (rot_c)
            2'd1: begin
                dst_start_c = I_ROTAG_DST_IMG + (h32_c - 32'd1) * PIX;
                col_step_c  = h32_c * PIX;
                row_step_c  = 32'd0 - PIX;
            end
            2'd2: begin
                dst_start_c = I_ROTAG_DST_IMG + (h32_c * w32_c - 32'd1) * PIX;
                col_step_c  = 32'd0 - PIX;
                row_step_c  = 32'd0 - w32_c * PIX;
            end
            2'd3: begin
                dst_start_c = I_ROTAG_DST_IMG + (w32_c - 32'd1) * h32_c * PIX;
                col_step_c  = 32'd0 - h32_c * PIX;
                row_step_c  = PIX;
            end
            default: ;
        endcase
    end

    // Next-state, counters and flags
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        w_d        = w_q;
        row_d      = row_q;
        col_d      = col_q;
        src_d      = src_q;
        dst_d      = dst_q;
        dst_row_d  = dst_row_q;
        col_step_d = col_step_q;
        row_step_d = row_step_q;
        new_h_d    = new_h_q;
        new_w_d    = new_w_q;
        valid_d    = valid_q;
        bef_set_c  = 1'b0;
        aft_set_c  = 1'b0;

        start_edge_c = I_ROTAG_START & ~start_prev_q;
        accept_c     = valid_q & I_ROTAG_ADDR_READY;
        row_end_c    = (col_q == w_q - DIM_W'(1));
        last_c       = row_end_c & (row_q == h_q - DIM_W'(1));

        if (I_ROTAG_SOFT_RST) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_edge_c) state_d = ST_LOAD;
                ST_LOAD: begin
                    h_d        = I_ROTAG_IMG_H;
                    w_d        = I_ROTAG_IMG_W;
                    new_h_d    = rot_c[0] ? I_ROTAG_IMG_W : I_ROTAG_IMG_H;
                    new_w_d    = rot_c[0] ? I_ROTAG_IMG_H : I_ROTAG_IMG_W;
                    col_step_d = col_step_c;
                    row_step_d = row_step_c;
                    src_d      = I_ROTAG_SRC_IMG;
                    dst_d      = dst_start_c;
                    dst_row_d  = dst_start_c;
                    row_d      = '0;
                    col_d      = '0;
                    bef_set_c  = 1'b1;
                    if (I_ROTAG_IMG_H == '0 || I_ROTAG_IMG_W == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    // VALID low inside RUN is the one drain cycle after the final accept
                    if (!valid_q) begin
                        state_d = ST_DONE;
                    end else if (accept_c) begin
                        if (last_c) begin
                            valid_d = 1'b0;
                        end else if (row_end_c) begin
                            col_d     = '0;
                            row_d     = row_q + DIM_W'(1);
                            src_d     = src_q + PIX;
                            dst_row_d = dst_row_q + row_step_q;
                            dst_d     = dst_row_q + row_step_q;
                        end else begin
                            col_d = col_q + DIM_W'(1);
                            src_d = src_q + PIX;
                            dst_d = dst_q + col_step_q;
                        end
                    end
                end
                ST_DONE: begin
                    aft_set_c = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        bef_d  = (bef_q & ~I_ROTAG_INTR_CLEAR) | bef_set_c;
        aft_d  = (aft_q & ~I_ROTAG_INTR_CLEAR) | aft_set_c;
    end

    always_ff @(posedge I_ROTAG_CLK or posedge I_ROTAG_RESET) begin
        if (I_ROTAG_RESET) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            h_q          <= '0;
            w_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            dst_row_q    <= '0;
            col_step_q   <= '0;
            row_step_q   <= '0;
            new_h_q      <= '0;
            new_w_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            bef_q        <= 1'b0;
            aft_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= I_ROTAG_START;
            h_q          <= h_d;
            w_q          <= w_d;
            row_q        <= row_d;
            col_q        <= col_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            dst_row_q    <= dst_row_d;
            col_step_q   <= col_step_d;
            row_step_q   <= row_step_d;
            new_h_q      <= new_h_d;
            new_w_q      <= new_w_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            bef_q        <= bef_d;
            aft_q        <= aft_d;
        end
    end

`ifdef ROTAG_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Counts LOAD through DONE; saturates and holds after the job
    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_LOAD) begin
            perf_d = 32'd1;
        end else if ((state_q == ST_RUN || state_q == ST_DONE) && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge I_ROTAG_CLK or posedge I_ROTAG_RESET) begin
        if (I_ROTAG_RESET) perf_q <= '0;
        else               perf_q <= perf_d;
    end

    assign O_ROTAG_PERF_CYC = perf_q;
`else
    assign O_ROTAG_PERF_CYC = '0;
`endif

    assign O_ROTAG_SRC_ADDR   = src_q;
    assign O_ROTAG_DST_ADDR   = dst_q;
    assign O_ROTAG_ADDR_VALID = valid_q;
    assign O_ROTAG_NEW_H      = new_h_q;
    assign O_ROTAG_NEW_W      = new_w_q;
    assign O_ROTAG_BUSY       = busy_q;
    assign O_ROTAG_BEF_MASK   = bef_q;
    assign O_ROTAG_AFT_MASK   = aft_q;
    assign O_ROTAG_INTR       = (bef_q | aft_q) & ~I_ROTAG_INTR_MASK;

endmodule

// File: tb/tb_rot_addr_gen.sv
// Directed bench for rot_addr_gen: address sequences per rotation, stalls, flags, soft/async reset.
module tb_rot_addr_gen;

    logic        clk, rst;
    logic [31:0] src_img, dst_img;
    logic [15:0] img_h, img_w;
    logic [1:0]  mode;
    logic        dir, start, soft_rst, intr_mask, intr_clear, ready;
    logic [31:0] src_addr, dst_addr, perf_cyc;
    logic        valid, busy, bef, aft, intr;
    logic [15:0] new_h, new_w;

    int checks = 0;
    int errors = 0;

    rot_addr_gen #(.PIX_BYTES(4), .DIM_W(16)) dut (
        .I_ROTAG_CLK(clk), .I_ROTAG_RESET(rst),
        .I_ROTAG_SRC_IMG(src_img), .I_ROTAG_DST_IMG(dst_img),
        .I_ROTAG_IMG_H(img_h), .I_ROTAG_IMG_W(img_w),
        .I_ROTAG_MODE(mode), .I_ROTAG_DIR(dir), .I_ROTAG_START(start),
        .I_ROTAG_SOFT_RST(soft_rst), .I_ROTAG_INTR_MASK(intr_mask),
        .I_ROTAG_INTR_CLEAR(intr_clear), .I_ROTAG_ADDR_READY(ready),
        .O_ROTAG_SRC_ADDR(src_addr), .O_ROTAG_DST_ADDR(dst_addr),
        .O_ROTAG_ADDR_VALID(valid), .O_ROTAG_NEW_H(new_h), .O_ROTAG_NEW_W(new_w),
        .O_ROTAG_BUSY(busy), .O_ROTAG_BEF_MASK(bef), .O_ROTAG_AFT_MASK(aft),
        .O_ROTAG_INTR(intr), .O_ROTAG_PERF_CYC(perf_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Destination address straight from the index formulas
    function automatic logic [31:0] exp_dst(input int h, input int w, input int rot, input int k,
                                            input logic [31:0] db);
        int r, c, idx;
        r = k / w;
        c = k % w;
        case (rot)
            1:       idx = c * h + (h - 1 - r);
            2:       idx = (h - 1 - r) * w + (w - 1 - c);
            3:       idx = (w - 1 - c) * h + r;
            default: idx = r * w + c;
        endcase
        return db + 32'(idx * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        intr_clear = 1'b1;
        tick();
        intr_clear = 1'b0;
    endtask

    // Runs one job to completion, checking every accepted pair and stall stability
    task automatic run_job(input int h, input int w, input int m, input int d,
                           input logic [31:0] sb, input logic [31:0] db,
                           input int rdy_pct, input bit disturb, output int npairs);
        int cyc, k, rot;
        bit stall, saw_valid;
        logic [31:0] st_src, st_dst;
        rot = d ? ((4 - m) % 4) : m;
        img_h = 16'(h); img_w = 16'(w); mode = 2'(m); dir = d[0];
        src_img = sb; dst_img = db;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; k = 0; stall = 0; saw_valid = 0;
        st_src = '0; st_dst = '0;
        while (busy && cyc < 1000) begin
            if (stall) begin
                check("stall_valid", 32'(valid), 32'd1);
                check("stall_src", src_addr, st_src);
                check("stall_dst", dst_addr, st_dst);
            end
            ready = ($urandom_range(99) < rdy_pct);
            stall = 0;
            if (valid) begin
                if (!saw_valid) check("first_lat", 32'(cyc), 32'd1);
                saw_valid = 1;
                if (ready) begin
                    check("src", src_addr, sb + 32'(k * 4));
                    check("dst", dst_addr, exp_dst(h, w, rot, k, db));
                    k++;
                end else begin
                    stall = 1;
                    st_src = src_addr;
                    st_dst = dst_addr;
                end
            end
            if (disturb && cyc == 3) begin
                start = 1'b1;
                img_h = 16'd9; img_w = 16'd7; mode = 2'd2; src_img = 32'hDEAD_0000;
            end
            if (disturb && cyc == 4) start = 1'b0;
            tick();
            cyc++;
        end
        ready = 1'b0;
        if (cyc >= 1000) check("timeout", 32'd1, 32'd0);
        check("pair_count", 32'(k), 32'(h * w));
        check("aft_set", 32'(aft), 32'd1);
        npairs = k;
    endtask

    int n;

    initial begin
        rst = 1'b1; src_img = '0; dst_img = '0; img_h = '0; img_w = '0; mode = '0; dir = 1'b0;
        start = 1'b0; soft_rst = 1'b0; intr_mask = 1'b0; intr_clear = 1'b0; ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_src", src_addr, 32'd0);
        check("rst_newh", 32'(new_h), 32'd0);
        check("rst_flags", {30'd0, bef, aft}, 32'd0);
        rst = 1'b0;
        tick();

        // 0 deg, 2x3
        run_job(2, 3, 0, 0, 32'h1000, 32'h2000, 100, 1'b0, n);
        check("m0_newh", 32'(new_h), 32'd2);
        check("m0_neww", 32'(new_w), 32'd3);
        check("m0_intr", 32'(intr), 32'd1);
        pulse_clear();

        // 90 deg clockwise
        run_job(2, 3, 1, 0, 32'h0, 32'h0, 100, 1'b0, n);
        check("m90_newh", 32'(new_h), 32'd3);
        check("m90_neww", 32'(new_w), 32'd2);
        pulse_clear();

        // 90 deg counter-clockwise is 270
        run_job(2, 3, 1, 1, 32'h0, 32'h0, 100, 1'b0, n);
        check("m270_newh", 32'(new_h), 32'd3);
        pulse_clear();

        // 180 deg
        run_job(2, 3, 2, 0, 32'h0, 32'h0, 100, 1'b0, n);
        check("m180_newh", 32'(new_h), 32'd2);
        pulse_clear();

        // 4x4 with random stalls, config churn and a START edge mid-job
        run_job(4, 4, 3, 0, 32'h4000, 32'h8000, 30, 1'b1, n);
        repeat (3) tick();
        check("no_restart", 32'(busy), 32'd0);
        pulse_clear();

        // 1x1 and 1xN
        run_job(1, 1, 1, 0, 32'h10, 32'h20, 100, 1'b0, n);
        run_job(1, 5, 3, 0, 32'h10, 32'h100, 70, 1'b0, n);
        pulse_clear();

        // Zero-size job: no pairs, both flags, mask and clear
        run_job(0, 5, 0, 0, 32'h0, 32'h0, 100, 1'b0, n);
        check("zero_bef", 32'(bef), 32'd1);
        check("zero_intr", 32'(intr), 32'd1);
        intr_mask = 1'b1;
        #1;
        check("masked_intr", 32'(intr), 32'd0);
        pulse_clear();
        check("cleared", {30'd0, bef, aft}, 32'd0);
        intr_mask = 1'b0;

        // Soft reset after 3 accepted pairs
        img_h = 16'd2; img_w = 16'd3; mode = 2'd0; dir = 1'b0;
        src_img = 32'h1000; dst_img = 32'h2000; ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("sr_pair3", src_addr, 32'h100C);
        soft_rst = 1'b1; ready = 1'b0;
        tick();
        soft_rst = 1'b0;
        check("sr_valid", 32'(valid), 32'd0);
        check("sr_busy", 32'(busy), 32'd0);
        check("sr_aft", 32'(aft), 32'd0);
        check("sr_bef", 32'(bef), 32'd1);
        check("sr_newh", 32'(new_h), 32'd2);
        tick();
        run_job(2, 3, 0, 0, 32'h1000, 32'h2000, 100, 1'b0, n);
        pulse_clear();

        // Busy-cycle counter on a 2x2 job
        run_job(2, 2, 0, 0, 32'h0, 32'h0, 100, 1'b0, n);
`ifdef ROTAG_PERF_CNT_EN
        check("perf", perf_cyc, 32'd7);
`else
        check("perf", perf_cyc, 32'd0);
`endif
        pulse_clear();

        // Async reset mid-job
        img_h = 16'd4; img_w = 16'd4; ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bef", 32'(bef), 32'd0);
        tick();
        rst = 1'b0;
        ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
